// File: rtl/common_pkg.sv
// Shared fabric types used across the tile: tile ids, fabric opcodes,
// arbitration cardinal directions and the tile transaction record.
package common_pkg;

    typedef logic [7:0] t_tile_id;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    typedef enum logic [2:0] {
        NULL_CARDINAL = 3'd0,
        NORTH         = 3'd1,
        SOUTH         = 3'd2,
        EAST          = 3'd3,
        WEST          = 3'd4
    } t_cardinal;

    typedef struct packed {
        t_cardinal   next_tile_fifo_arb_id;
        t_opcode     opcode;
        t_tile_id    requestor_id;
        logic [31:0] address;
        logic [31:0] data;
    } t_tile_trans;

endpackage

// File: rtl/mini_core_pkg.sv
// Core-side definitions for the mini core: the core-to-fabric read tracker
// state encoding and the data value returned when a remote read times out.
package mini_core_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } t_c2f_trk_state;

    localparam logic [31:0] C2F_TIMEOUT_RD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mini_c2f_rd_tracker.sv
// mini_c2f_rd_tracker
// Turns core loads/stores that target another tile into C2F fabric requests.
// Stores are posted (stall only while the C2F FIFO is full). Loads stall the
// core until the matching RD_RSP returns on the fabric ingress, or until a
// timeout, and then deliver the data for one cycle at Q104H.
//
// Ports
//   Clock, Rst              : clock, synchronous active-low reset
//   local_tile_id           : id of this tile
//   DMemRdEnQ103H/WrEn      : core load / store request (both set = store)
//   DMemAddressQ103H        : core address, [31:24] selects the target tile
//   DMemWrDataQ103H         : store data
//   C2fReqFull              : C2F request FIFO full
//   C2fReqValidQ103H        : push strobe into the C2F FIFO
//   C2fReqQ103H             : transaction pushed into the C2F FIFO
//   CoreStallQ103H          : hold the core pipeline at Q103H
//   InFabricValidQ503H/Q503H: fabric ingress transaction
//   RdRspValidQ104H/DataQ104H: remote load data, one-cycle pulse
//   RdTimeoutErr            : sticky, set when a remote load timed out
//   StaleRspCnt             : saturating count of unmatched RD_RSPs for this tile
module mini_c2f_rd_tracker
    import common_pkg::*;
    import mini_core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] TIMEOUT_RD_DATA = C2F_TIMEOUT_RD_DATA
) (
    input  logic        Clock,
    input  logic        Rst,
    input  t_tile_id    local_tile_id,
    input  logic        DMemRdEnQ103H,
    input  logic        DMemWrEnQ103H,
    input  logic [31:0] DMemAddressQ103H,
    input  logic [31:0] DMemWrDataQ103H,
    input  logic        C2fReqFull,
    output logic        C2fReqValidQ103H,
    output t_tile_trans C2fReqQ103H,
    output logic        CoreStallQ103H,
    input  logic        InFabricValidQ503H,
    input  t_tile_trans InFabricQ503H,
    output logic        RdRspValidQ104H,
    output logic [31:0] RdRspDataQ104H,
    output logic        RdTimeoutErr,
    output logic [7:0]  StaleRspCnt
);

    // One extra bit so TIMEOUT_CYCLES itself is representable; the counter
    // never needs to wrap.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    t_c2f_trk_state   state;
    logic [23:0]      latchedAddr;
    logic [31:0]      capData;
    logic [CNT_W-1:0] timeoutCnt;

    logic [7:0] tgtTile;
    logic       nonLocal;
    logic       isStore;
    logic       isLoad;
    logic       rspToMe;
    logic       rspMatch;
    logic       takeMatch;
    logic       pushReq;
    logic       stallReq;

    assign tgtTile  = DMemAddressQ103H[31:24];
    assign nonLocal = (tgtTile != local_tile_id) && (tgtTile != 8'h00);
    // A request with both enables set is a store.
    assign isStore  = nonLocal && DMemWrEnQ103H;
    assign isLoad   = nonLocal && DMemRdEnQ103H && !DMemWrEnQ103H;

    assign rspToMe   = InFabricValidQ503H && (InFabricQ503H.opcode == RD_RSP)
                    && (InFabricQ503H.address[31:24] == local_tile_id);
    assign rspMatch  = rspToMe && (InFabricQ503H.address[23:0] == latchedAddr);
    assign takeMatch = (state == WAIT_RSP) && rspMatch;

    // Requestor id and arbitration id of ingress traffic are irrelevant here.
    logic unusedFabricBits;
    assign unusedFabricBits = ^{InFabricQ503H.requestor_id, InFabricQ503H.next_tile_fifo_arb_id};

    always_comb begin
        pushReq  = 1'b0;
        stallReq = 1'b0;
        case (state)
            IDLE: begin
                if (isStore) begin
                    pushReq  = !C2fReqFull;
                    stallReq = C2fReqFull;
                end else if (isLoad) begin
                    pushReq  = !C2fReqFull;
                    stallReq = 1'b1;
                end
            end
            ISSUE: begin
                pushReq  = !C2fReqFull;
                stallReq = 1'b1;
            end
            WAIT_RSP: stallReq = 1'b1;
            default: ;
        endcase
    end

    // Request-side outputs are held low while Rst is asserted so nothing is
    // pushed into the fabric during reset.
    always_comb begin
        C2fReqQ103H = '0;
        if (Rst) begin
            C2fReqQ103H.address               = DMemAddressQ103H;
            C2fReqQ103H.data                  = DMemWrDataQ103H;
            C2fReqQ103H.opcode                = DMemWrEnQ103H ? WR : RD;
            C2fReqQ103H.requestor_id          = local_tile_id;
            C2fReqQ103H.next_tile_fifo_arb_id = NULL_CARDINAL;
        end
    end

    assign C2fReqValidQ103H = Rst && pushReq;
    assign CoreStallQ103H   = Rst && stallReq;
    assign RdRspValidQ104H  = Rst && (state == DELIVER);
    assign RdRspDataQ104H   = RdRspValidQ104H ? capData : 32'h0;

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state        <= IDLE;
            latchedAddr  <= '0;
            capData      <= '0;
            timeoutCnt   <= '0;
            RdTimeoutErr <= 1'b0;
            StaleRspCnt  <= '0;
        end else begin
            if (rspToMe && !takeMatch && (StaleRspCnt != 8'hFF))
                StaleRspCnt <= StaleRspCnt + 8'd1;

            case (state)
                IDLE, ISSUE: begin
                    if ((state == ISSUE) || isLoad) begin
                        if (!C2fReqFull) begin
                            latchedAddr <= DMemAddressQ103H[23:0];
                            timeoutCnt  <= '0;
                            state       <= WAIT_RSP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response in the final cycle still beats the timeout.
                    if (rspMatch) begin
                        capData <= InFabricQ503H.data;
                        state   <= DELIVER;
                    end else if (timeoutCnt == CNT_LAST) begin
                        capData      <= TIMEOUT_RD_DATA;
                        RdTimeoutErr <= 1'b1;
                        state        <= DELIVER;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mini_c2f_rd_tracker.sv
// Testbench for mini_c2f_rd_tracker: directed remote-load, back-pressure,
// store, timeout, stale-response and reset scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mini_c2f_rd_tracker;
    import common_pkg::*;

    localparam int          TO      = 16;
    localparam logic [7:0]  MY_TILE = 8'h03;
    localparam logic [31:0] DEAD    = 32'hDEAD_BEEF;

    logic        Clock = 1'b0;
    logic        Rst;
    t_tile_id    tileId;
    logic        rdEn, wrEn, full, finV;
    logic [31:0] addr, wdata;
    t_tile_trans finT;
    logic        pushO, stallO, rspVO, errO;
    t_tile_trans reqO;
    logic [31:0] rspDO;
    logic [7:0]  staleO;

    int nChecks = 0;
    int nFails  = 0;

    // observations sampled each cycle
    logic        oPush, oStall, oRspV, oErr;
    logic [31:0] oRspD;
    logic [7:0]  oStale;
    t_tile_trans oReq;

    // reference model: an outstanding remote load and what is owed to the core
    bit          mBusy, mPushed, mDeliver, mErr;
    int          mWait, mStale;
    logic [23:0] mAddr;
    logic [31:0] mData;

    // model expectations for the current cycle
    bit          ePush, eStall, eRspV, eErr;
    logic [31:0] eRspD;
    int          eStale;
    t_tile_trans eReq;

    always #5 Clock = ~Clock;

    mini_c2f_rd_tracker #(.TIMEOUT_CYCLES(TO), .TIMEOUT_RD_DATA(DEAD)) dut (
        .Clock              (Clock),
        .Rst                (Rst),
        .local_tile_id      (tileId),
        .DMemRdEnQ103H      (rdEn),
        .DMemWrEnQ103H      (wrEn),
        .DMemAddressQ103H   (addr),
        .DMemWrDataQ103H    (wdata),
        .C2fReqFull         (full),
        .C2fReqValidQ103H   (pushO),
        .C2fReqQ103H        (reqO),
        .CoreStallQ103H     (stallO),
        .InFabricValidQ503H (finV),
        .InFabricQ503H      (finT),
        .RdRspValidQ104H    (rspVO),
        .RdRspDataQ104H     (rspDO),
        .RdTimeoutErr       (errO),
        .StaleRspCnt        (staleO)
    );

    task automatic setIdle();
        rdEn = 1'b0; wrEn = 1'b0; addr = 32'h0; wdata = 32'h0;
        full = 1'b0; finV = 1'b0; finT = '0;
    endtask

    task automatic sendRsp(input logic [31:0] a, input logic [31:0] d);
        finV = 1'b1;
        finT = '0;
        finT.opcode = RD_RSP;
        finT.address = a;
        finT.data = d;
        finT.requestor_id = 8'h05;
    endtask

    // Called at a negedge with inputs set: samples outputs, forms the model's
    // expectations, advances one clock and returns at the next negedge.
    task automatic tick();
        bit nonLocal, isSt, isLd, toMe, matched;
        #1;
        oPush = pushO; oStall = stallO; oRspV = rspVO; oRspD = rspDO;
        oErr = errO; oStale = staleO; oReq = reqO;

        nonLocal = (addr[31:24] != MY_TILE) && (addr[31:24] != 8'h00);
        isSt = nonLocal && wrEn;
        isLd = nonLocal && rdEn && !wrEn;
        toMe = finV && (finT.opcode == RD_RSP) && (finT.address[31:24] == MY_TILE);
        matched = 1'b0;

        eErr = mErr; eStale = mStale;
        ePush = 1'b0; eStall = 1'b0; eRspV = 1'b0; eRspD = 32'h0;
        eReq = '0;
        eReq.address = addr; eReq.data = wdata;
        eReq.opcode = wrEn ? WR : RD;
        eReq.requestor_id = MY_TILE;
        eReq.next_tile_fifo_arb_id = NULL_CARDINAL;
        if (Rst) begin
            if (mDeliver) begin eRspV = 1'b1; eRspD = mData; end
            else if (mBusy && mPushed) eStall = 1'b1;
            else if (mBusy) begin eStall = 1'b1; ePush = !full; end
            else if (isSt) begin ePush = !full; eStall = full; end
            else if (isLd) begin eStall = 1'b1; ePush = !full; end
        end

        @(posedge Clock);
        if (!Rst) begin
            mBusy = 0; mPushed = 0; mDeliver = 0; mErr = 0;
            mWait = 0; mStale = 0; mAddr = '0; mData = '0;
        end else begin
            if (mDeliver) begin
                mDeliver = 0;
            end else if (mBusy && mPushed) begin
                if (toMe && finT.address[23:0] == mAddr) begin
                    matched = 1'b1; mDeliver = 1; mData = finT.data; mBusy = 0;
                end else if (mWait == TO - 1) begin
                    mDeliver = 1; mData = DEAD; mErr = 1; mBusy = 0;
                end else begin
                    mWait++;
                end
            end else if (mBusy || isLd) begin
                mBusy = 1;
                mPushed = 0;
                if (!full) begin mPushed = 1; mWait = 0; mAddr = addr[23:0]; end
            end
            if (toMe && !matched && mStale < 255) mStale++;
        end
        @(negedge Clock);
    endtask

    task automatic doReset();
        Rst = 1'b0;
        setIdle();
        tick();
        tick();
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        tick();
        nChecks++; if (oPush !== 1'b0) begin nFails++; $display("FAIL reset_push: got %b want 0", oPush); end
        nChecks++; if (oStall !== 1'b0) begin nFails++; $display("FAIL reset_stall: got %b want 0", oStall); end
        nChecks++; if (oRspV !== 1'b0) begin nFails++; $display("FAIL reset_rspv: got %b want 0", oRspV); end
        nChecks++; if (oRspD !== 32'h0) begin nFails++; $display("FAIL reset_rspd: got %h want 0", oRspD); end
        nChecks++; if (oErr !== 1'b0) begin nFails++; $display("FAIL reset_err: got %b want 0", oErr); end
        nChecks++; if (oStale !== 8'h0) begin nFails++; $display("FAIL reset_stale: got %h want 0", oStale); end
    endtask

    // Shared shape of the two directed remote-load scenarios: the response
    // lands in cycle rspCyc, the FIFO is full for the first fullCycles cycles.
    task automatic run_load(input string nm, input int fullCycles, input logic [31:0] a,
                            input int rspCyc, input logic [31:0] d);
        int pushes = 0;
        bit xStall, xPush, xV;
        doReset();
        for (int c = 0; c <= rspCyc + 2; c++) begin
            setIdle();
            if (c <= rspCyc + 1) begin rdEn = 1'b1; addr = a; end
            full = (c < fullCycles);
            if (c == rspCyc) sendRsp({MY_TILE, a[23:0]}, d);
            tick();
            xStall = (c <= rspCyc);
            xPush = (c == fullCycles);
            xV = (c == rspCyc + 1);
            if (oPush) pushes++;
            nChecks++; if (oStall !== xStall) begin nFails++; $display("FAIL %s_stall c%0d: got %b want %b", nm, c, oStall, xStall); end
            nChecks++; if (oPush !== xPush) begin nFails++; $display("FAIL %s_push c%0d: got %b want %b", nm, c, oPush, xPush); end
            nChecks++; if (oRspV !== xV) begin nFails++; $display("FAIL %s_rspv c%0d: got %b want %b", nm, c, oRspV, xV); end
            nChecks++; if (oRspD !== (xV ? d : 32'h0)) begin nFails++; $display("FAIL %s_rspd c%0d: got %h want %h", nm, c, oRspD, xV ? d : 32'h0); end
            if (xPush) begin
                nChecks++;
                if (oReq.address !== a || oReq.opcode !== RD || oReq.requestor_id !== MY_TILE || oReq.next_tile_fifo_arb_id !== NULL_CARDINAL) begin
                    nFails++; $display("FAIL %s_req: got addr %h op %0d req %h want addr %h op RD req %h", nm, oReq.address, oReq.opcode, oReq.requestor_id, a, MY_TILE);
                end
            end
        end
        nChecks++; if (pushes != 1) begin nFails++; $display("FAIL %s_pushcount: got %0d want 1", nm, pushes); end
        nChecks++; if (oErr !== 1'b0 || oStale !== 8'h0) begin nFails++; $display("FAIL %s_errstale: got err %b stale %0d want 0 0", nm, oErr, oStale); end
    endtask

    task automatic test_remote_load();
        run_load("load", 0, 32'h0500_0010, 6, 32'h1234_5678);
    endtask

    task automatic test_full_load();
        run_load("fullload", 3, 32'h0700_0040, 6, 32'hA5A5_0F0F);
    endtask

    task automatic test_store_full();
        bit xStall, xPush;
        int pushes = 0;
        doReset();
        for (int c = 0; c < 6; c++) begin
            setIdle();
            if (c < 3) begin wrEn = 1'b1; addr = 32'h0900_0080; wdata = 32'hCAFE_0001; full = (c < 2); end
            if (c == 4) begin rdEn = 1'b1; wrEn = 1'b1; addr = 32'h0900_0084; wdata = 32'hCAFE_0002; end
            tick();
            xStall = (c < 2);
            xPush = (c == 2) || (c == 4);
            if (oPush) pushes++;
            nChecks++; if (oStall !== xStall) begin nFails++; $display("FAIL store_stall c%0d: got %b want %b", c, oStall, xStall); end
            nChecks++; if (oPush !== xPush) begin nFails++; $display("FAIL store_push c%0d: got %b want %b", c, oPush, xPush); end
            if (xPush) begin
                nChecks++;
                if (oReq.opcode !== WR || oReq.data !== wdata || oReq.address !== addr) begin
                    nFails++; $display("FAIL store_req c%0d: got op %0d data %h addr %h want WR %h %h", c, oReq.opcode, oReq.data, oReq.address, wdata, addr);
                end
            end
        end
        nChecks++; if (pushes != 2) begin nFails++; $display("FAIL store_pushcount: got %0d want 2", pushes); end
    endtask

    task automatic test_local();
        logic [7:0] tiles [2];
        tiles[0] = MY_TILE; tiles[1] = 8'h00;
        doReset();
        for (int i = 0; i < 8; i++) begin
            setIdle();
            addr = {tiles[i % 2], 24'(i * 4)};
            rdEn = (i / 2) % 2 == 0;
            wrEn = !rdEn || i >= 6;
            full = i[0] ^ i[2];
            // non-RD_RSP traffic addressed to this tile must be ignored
            finV = 1'b1; finT = '0; finT.opcode = WR; finT.address = {MY_TILE, 24'h0};
            tick();
            nChecks++; if (oPush !== 1'b0 || oStall !== 1'b0) begin nFails++; $display("FAIL local_access i%0d: got push %b stall %b want 0 0", i, oPush, oStall); end
        end
        setIdle();
        tick();
        nChecks++; if (oStale !== 8'h0) begin nFails++; $display("FAIL local_nonrsp_stale: got %0d want 0", oStale); end
    endtask

    task automatic test_timeout();
        bit xStall, xV;
        doReset();
        for (int c = 0; c < 19; c++) begin
            setIdle();
            if (c < 18) begin rdEn = 1'b1; addr = 32'h0A00_0100; end
            tick();
            xStall = (c < 17);
            xV = (c == 17);
            nChecks++; if (oStall !== xStall) begin nFails++; $display("FAIL timeout_stall c%0d: got %b want %b", c, oStall, xStall); end
            nChecks++; if (oRspV !== xV) begin nFails++; $display("FAIL timeout_rspv c%0d: got %b want %b", c, oRspV, xV); end
            nChecks++; if (oErr !== (c >= 17)) begin nFails++; $display("FAIL timeout_err c%0d: got %b want %b", c, oErr, c >= 17); end
            if (xV) begin
                nChecks++; if (oRspD !== DEAD) begin nFails++; $display("FAIL timeout_data: got %h want %h", oRspD, DEAD); end
            end
        end
        setIdle();
        sendRsp(32'h0300_0100, 32'h1111_2222);
        tick();
        setIdle();
        tick();
        nChecks++; if (oStale !== 8'd1) begin nFails++; $display("FAIL timeout_late_stale: got %0d want 1", oStale); end
        nChecks++; if (oErr !== 1'b1 || oRspV !== 1'b0) begin nFails++; $display("FAIL timeout_sticky: got err %b rspv %b want 1 0", oErr, oRspV); end
    endtask

    task automatic test_mismatch();
        doReset();
        for (int c = 0; c < 8; c++) begin
            setIdle();
            if (c < 7) begin rdEn = 1'b1; addr = 32'h0B00_0200; end
            if (c == 3) sendRsp(32'h0300_0204, 32'h0000_0BAD);
            if (c == 5) sendRsp(32'h0300_0200, 32'h0BAD_F00D);
            tick();
            nChecks++; if (oStall !== (c < 6)) begin nFails++; $display("FAIL mismatch_stall c%0d: got %b want %b", c, oStall, c < 6); end
            nChecks++; if (oRspV !== (c == 6)) begin nFails++; $display("FAIL mismatch_rspv c%0d: got %b want %b", c, oRspV, c == 6); end
            if (c == 6) begin
                nChecks++; if (oRspD !== 32'h0BAD_F00D) begin nFails++; $display("FAIL mismatch_data: got %h want 0BADF00D", oRspD); end
            end
            if (c >= 4) begin
                nChecks++; if (oStale !== 8'd1) begin nFails++; $display("FAIL mismatch_stale c%0d: got %0d want 1", c, oStale); end
            end
        end
    endtask

    task automatic test_reset_wait();
        doReset();
        for (int c = 0; c < 3; c++) begin
            setIdle(); rdEn = 1'b1; addr = 32'h0C00_0300;
            tick();
        end
        nChecks++; if (oStall !== 1'b1) begin nFails++; $display("FAIL rstwait_waiting: got stall %b want 1", oStall); end
        setIdle();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        nChecks++;
        if (oPush !== 1'b0 || oStall !== 1'b0 || oRspV !== 1'b0 || oRspD !== 32'h0 || oErr !== 1'b0 || oStale !== 8'h0) begin
            nFails++; $display("FAIL rstwait_outputs: got push %b stall %b rspv %b rspd %h err %b stale %0d want all 0", oPush, oStall, oRspV, oRspD, oErr, oStale);
        end
        sendRsp(32'h0300_0300, 32'h7777_8888);
        tick();
        setIdle();
        tick();
        nChecks++; if (oStale !== 8'd1) begin nFails++; $display("FAIL rstwait_stale: got %0d want 1", oStale); end
        nChecks++; if (oRspV !== 1'b0 || oStall !== 1'b0) begin nFails++; $display("FAIL rstwait_abandoned: got rspv %b stall %b want 0 0", oRspV, oStall); end
    endtask

    task automatic test_stale_saturate();
        doReset();
        for (int i = 0; i < 260; i++) begin
            setIdle();
            sendRsp({MY_TILE, 24'(i)}, 32'(i));
            tick();
        end
        setIdle();
        tick();
        nChecks++; if (oStale !== 8'hFF) begin nFails++; $display("FAIL stale_saturate: got %h want ff", oStale); end
    endtask

    task automatic randReq();
        logic [7:0] tgt;
        int kind;
        case ($urandom_range(0, 3))
            0: tgt = 8'h00;
            1: tgt = MY_TILE;
            default: tgt = 8'h10 + 8'($urandom_range(0, 15));
        endcase
        kind = $urandom_range(0, 4);
        rdEn = (kind == 1) || (kind == 3) || (kind == 4);
        wrEn = (kind == 2) || (kind == 3);
        addr = {tgt, 24'($urandom_range(0, 7)) << 2};
        wdata = $urandom;
    endtask

    task automatic test_random();
        doReset();
        randReq();
        for (int c = 0; c < 3000; c++) begin
            if (!eStall) randReq();
            full = ($urandom_range(0, 3) == 0);
            Rst = ($urandom_range(0, 399) != 0);
            finV = ($urandom_range(0, 2) == 0);
            finT = '0;
            finT.opcode = ($urandom_range(0, 4) == 0) ? WR : RD_RSP;
            finT.address[31:24] = ($urandom_range(0, 6) == 0) ? 8'h07 : MY_TILE;
            finT.address[23:0] = (mBusy && mPushed && $urandom_range(0, 1) == 1) ? mAddr : 24'($urandom_range(0, 7)) << 2;
            finT.data = $urandom;
            tick();
            nChecks++; if (oPush !== ePush) begin nFails++; $display("FAIL rand_push c%0d: got %b want %b", c, oPush, ePush); end
            nChecks++; if (oStall !== eStall) begin nFails++; $display("FAIL rand_stall c%0d: got %b want %b", c, oStall, eStall); end
            nChecks++; if (oRspV !== eRspV) begin nFails++; $display("FAIL rand_rspv c%0d: got %b want %b", c, oRspV, eRspV); end
            nChecks++; if (oRspD !== eRspD) begin nFails++; $display("FAIL rand_rspd c%0d: got %h want %h", c, oRspD, eRspD); end
            nChecks++; if (oErr !== eErr) begin nFails++; $display("FAIL rand_err c%0d: got %b want %b", c, oErr, eErr); end
            nChecks++; if (oStale !== eStale[7:0]) begin nFails++; $display("FAIL rand_stale c%0d: got %0d want %0d", c, oStale, eStale); end
            if (ePush) begin
                nChecks++; if (oReq !== eReq) begin nFails++; $display("FAIL rand_req c%0d: got %h want %h", c, oReq, eReq); end
            end
        end
        Rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tileId = MY_TILE;
        Rst = 1'b0;
        setIdle();
        mBusy = 0; mPushed = 0; mDeliver = 0; mErr = 0;
        mWait = 0; mStale = 0; mAddr = '0; mData = '0;
        eStall = 0;
        @(negedge Clock);
        test_reset();
        test_remote_load();
        test_full_load();
        test_store_full();
        test_local();
        test_timeout();
        test_mismatch();
        test_reset_wait();
        test_stale_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
